// File: rtl/config_sram_loader.sv
// rtl/config_sram_loader.sv - word-serial configuration loader with shadow/active bit store and multi-port readout
// Optional feature: define CONFIG_SRAM_READBACK_EN to add word-serial readback of the active store.
module config_sram_loader #(
    parameter int ADDR_BITS = 4,
    parameter int MEM_SIZE  = 2**ADDR_BITS,
    parameter int WORD_BITS = 8,
    parameter int NUM_PORTS = 2
) (
    input  logic                           cclk,
    input  logic                           rst,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] addr,
    output logic [NUM_PORTS-1:0]           out,
    input  logic                           cfg_start,
    input  logic                           cfg_valid,
    input  logic [WORD_BITS-1:0]           cfg_data,
    output logic                           cfg_ready,
    output logic                           cfg_busy,
    output logic                           cfg_done
`ifdef CONFIG_SRAM_READBACK_EN
    ,
    input  logic                           rb_start,
    output logic                           rb_valid,
    output logic [WORD_BITS-1:0]           rb_data,
    input  logic                           rb_ready
`endif
);

    localparam int NWORDS   = MEM_SIZE / WORD_BITS;
    localparam int CNT_BITS = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
`ifdef CONFIG_SRAM_READBACK_EN
        ,
        RB
`endif
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [MEM_SIZE-1:0]   shadow_q;
    logic [MEM_SIZE-1:0]   mem_q;

    logic                  cnt_clr;
    logic                  cnt_inc;
    logic                  shadow_we;
    logic                  commit;

    // State register; reset returns to IDLE and abandons any load in flight.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; a restart in LOAD drops the word offered that cycle.
    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        cfg_busy  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        shadow_we = 1'b0;
        commit    = 1'b0;
`ifdef CONFIG_SRAM_READBACK_EN
        rb_valid  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_clr = 1'b1;
                end
`ifdef CONFIG_SRAM_READBACK_EN
                else if (rb_start) begin
                    state_d = RB;
                    cnt_clr = 1'b1;
                end
`endif
            end
            LOAD: begin
                cfg_ready = 1'b1;
                cfg_busy  = 1'b1;
                if (cfg_start) begin
                    cnt_clr = 1'b1;
                end else if (cfg_valid) begin
                    shadow_we = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = COMMIT;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            COMMIT: begin
                cfg_busy = 1'b1;
                commit   = 1'b1;
                state_d  = IDLE;
            end
`ifdef CONFIG_SRAM_READBACK_EN
            RB: begin
                cfg_busy = 1'b1;
                rb_valid = 1'b1;
                if (rb_ready) begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Word counter, shadow capture, shadow-to-active copy and the done pulse.
    always_ff @(posedge cclk) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            mem_q    <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= commit;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (shadow_we) begin
                for (int k = 0; k < NWORDS; k++) begin
                    if (cnt_q == CNT_BITS'(k)) begin
                        shadow_q[k*WORD_BITS +: WORD_BITS] <= cfg_data;
                    end
                end
            end
            if (commit) begin
                mem_q <= shadow_q;
            end
        end
    end

    // Read ports look only at the active store, so a half-loaded shadow is never visible.
    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            out[i] = mem_q[addr[i*ADDR_BITS +: ADDR_BITS]];
        end
    end

`ifdef CONFIG_SRAM_READBACK_EN
    // Readback word selected by the shared word counter.
    always_comb begin
        rb_data = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (cnt_q == CNT_BITS'(k)) begin
                rb_data = mem_q[k*WORD_BITS +: WORD_BITS];
            end
        end
    end
`endif

endmodule

// File: tb/tb_config_sram_loader.sv
// tb/tb_config_sram_loader.sv - self-checking bench for config_sram_loader
module tb_config_sram_loader;

    localparam int AB = 4;
    localparam int MS = 16;
    localparam int WB = 8;
    localparam int NP = 2;
    localparam int NW = MS / WB;

    logic          cclk = 1'b0;
    logic          rst;
    logic [NP*AB-1:0] addr;
    logic [NP-1:0] out;
    logic          cfg_start;
    logic          cfg_valid;
    logic [WB-1:0] cfg_data;
    logic          cfg_ready;
    logic          cfg_busy;
    logic          cfg_done;
`ifdef CONFIG_SRAM_READBACK_EN
    logic          rb_start;
    logic          rb_valid;
    logic [WB-1:0] rb_data;
    logic          rb_ready;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    config_sram_loader #(
        .ADDR_BITS(AB),
        .MEM_SIZE (MS),
        .WORD_BITS(WB),
        .NUM_PORTS(NP)
    ) dut (
`ifdef CONFIG_SRAM_READBACK_EN
        .rb_start (rb_start),
        .rb_valid (rb_valid),
        .rb_data  (rb_data),
        .rb_ready (rb_ready),
`endif
        .cclk     (cclk),
        .rst      (rst),
        .addr     (addr),
        .out      (out),
        .cfg_start(cfg_start),
        .cfg_valid(cfg_valid),
        .cfg_data (cfg_data),
        .cfg_ready(cfg_ready),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done)
    );

    always #5 cclk = ~cclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: words collected since the last start, committed one cycle after the last one.
    logic [MS-1:0] m_mem;
    logic [MS-1:0] m_asm;
    logic [WB-1:0] m_words[$];
    bit            m_loading;
    bit            m_pending;
    bit            m_done;
    bit            m_rb;
    int            m_idx;

    always @(posedge cclk) begin
        if (rst) begin
            m_mem = '0;
            m_loading = 0;
            m_pending = 0;
            m_done = 0;
            m_rb = 0;
            m_idx = 0;
            m_words.delete();
        end else begin
            m_done = 0;
            if (m_pending) begin
                m_mem = m_asm;
                m_pending = 0;
                m_done = 1;
            end else if (m_loading) begin
                if (cfg_start) begin
                    m_words.delete();
                end else if (cfg_valid) begin
                    m_words.push_back(cfg_data);
                    if (m_words.size() == NW) begin
                        for (int j = 0; j < NW; j++) m_asm[j*WB +: WB] = m_words[j];
                        m_words.delete();
                        m_loading = 0;
                        m_pending = 1;
                    end
                end
            end else if (m_rb) begin
`ifdef CONFIG_SRAM_READBACK_EN
                if (rb_ready) begin
                    if (m_idx == NW - 1) m_rb = 0;
                    else m_idx++;
                end
`endif
            end else begin
                if (cfg_start) begin
                    m_loading = 1;
                    m_words.delete();
                end
`ifdef CONFIG_SRAM_READBACK_EN
                else if (rb_start) begin
                    m_rb = 1;
                    m_idx = 0;
                end
`endif
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    logic [NP-1:0] e_out;
    always @(negedge cclk) begin
        if (chk_en) begin
            for (int i = 0; i < NP; i++) e_out[i] = m_mem[addr[i*AB +: AB]];
            check("out", 32'(out), 32'(e_out));
            check("cfg_ready", 32'(cfg_ready), 32'(m_loading));
            check("cfg_busy", 32'(cfg_busy), 32'(m_loading | m_pending | m_rb));
            check("cfg_done", 32'(cfg_done), 32'(m_done));
`ifdef CONFIG_SRAM_READBACK_EN
            check("rb_valid", 32'(rb_valid), 32'(m_rb));
            if (m_rb) check("rb_data", 32'(rb_data), 32'(m_mem[m_idx*WB +: WB]));
`endif
            if (cfg_done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send(input logic [WB-1:0] d);
        cfg_valid = 1'b1;
        cfg_data = d;
        tick();
        cfg_valid = 1'b0;
        cfg_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Walks both ports over every address against a literal expected image.
    task automatic scan(input string tag, input logic [MS-1:0] e);
        for (int i = 0; i < MS; i++) begin
            addr = {4'(MS - 1 - i), 4'(i)};
            @(negedge cclk);
            check(tag, 32'(out), 32'({e[MS-1-i], e[i]}));
            tick();
        end
    endtask

    int d0;

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        addr = {4'd5, 4'd3};
`ifdef CONFIG_SRAM_READBACK_EN
        rb_start = 1'b0;
        rb_ready = 1'b0;
`endif
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge cclk);
        check("rst_out", 32'(out), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h0);
        check("rst_busy", 32'(cfg_busy), 32'h0);
        check("rst_done", 32'(cfg_done), 32'h0);

        // Two back-to-back words, single commit.
        d0 = done_cnt;
        start_load();
        send(8'hA5);
        send(8'h3C);
        tick();
        addr = {4'd10, 4'd0};
        @(negedge cclk);
        check("model_mem_34", 32'(m_mem), 32'h3CA5);
        check("done_34", 32'(cfg_done), 32'h1);
        check("rd_34a", 32'(out), 32'h3);
        tick();
        addr = {4'd8, 4'd1};
        @(negedge cclk);
        check("rd_34b", 32'(out), 32'h0);
        idle(2);
        check("done_cnt_34", 32'(done_cnt - d0), 32'h1);

        // Gapped load; old image stays visible until the done pulse.
        addr = {4'd10, 4'd1};
        start_load();
        send(8'hFF);
        idle(3);
        send(8'h00);
        @(negedge cclk);
        check("hold_35", 32'(out), 32'h2);
        tick();
        addr = {4'd8, 4'd0};
        @(negedge cclk);
        check("rd_35", 32'(out), 32'h1);
        idle(1);

        // Restart mid-load discards the concurrent word; start during commit is ignored.
        d0 = done_cnt;
        start_load();
        send(8'h11);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 8'h99;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        send(8'h22);
        send(8'h44);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        idle(2);
        scan("scan_36", 16'h4422);
        check("done_cnt_36", 32'(done_cnt - d0), 32'h1);

        // Reset mid-load and mid-commit never commits.
        d0 = done_cnt;
        start_load();
        send(8'h5A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);
        check("busy_37", 32'(cfg_busy), 32'h0);
        scan("scan_37a", 16'h0000);
        start_load();
        send(8'h12);
        send(8'h34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);
        scan("scan_37b", 16'h0000);
        check("done_cnt_37", 32'(done_cnt - d0), 32'h0);

`ifdef CONFIG_SRAM_READBACK_EN
        start_load();
        send(8'hA5);
        send(8'h3C);
        idle(2);
        rb_start = 1'b1;
        tick();
        rb_start = 1'b0;
        rb_ready = 1'b1;
        @(negedge cclk);
        check("rb_w0", 32'(rb_data), 32'hA5);
        check("rb_v0", 32'(rb_valid), 32'h1);
        tick();
        rb_ready = 1'b0;
        cfg_start = 1'b1;
        @(negedge cclk);
        check("rb_w1", 32'(rb_data), 32'h3C);
        tick();
        cfg_start = 1'b0;
        rb_ready = 1'b1;
        @(negedge cclk);
        check("rb_w1_hold", 32'(rb_data), 32'h3C);
        tick();
        rb_ready = 1'b0;
        @(negedge cclk);
        check("rb_v_end", 32'(rb_valid), 32'h0);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
